fifo_rd_packer: RTL and testbench

Read-side consumer of the async FIFO, running entirely in the FIFO read clock domain. Pops DATA_WIDTH-bit entries through rd_en/rd_data/empty and packs PACK consecutive entries into one wide word. Presents packed words on a valid/ready output stream. A flush request emits a partial word with a byte-keep mask and a last marker.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_out_reg.sv | 63 ++++++
 rtl/fifo_rd_packer.sv | 138 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the FIFO read-side packer
package fifo_pkg;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        EMIT
    } state_t;

    // Pack counter must hold 0..PACK inclusive.
    function automatic int pack_cnt_width(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// rtl/fifo_out_reg.sv - single-entry valid/ready holding register for packed words
module fifo_out_reg #(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [KW-1:0] load_keep,
    input  logic          load_last,
    input  logic          out_ready,
    output logic          out_free,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [KW-1:0] out_keep,
    output logic          out_last
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [KW-1:0] keep_q, keep_d;
    logic          last_q, last_d;

    // Free when empty or being drained this cycle, so a new word replaces the old with no bubble.
    assign out_free = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            keep_d  = load_keep;
            last_d  = load_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO entries and packs PACK of them into one output word
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
    output logic                       fifo_rd_en,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_last,
    output logic [CNT_WIDTH-1:0]       word_count
);

    localparam int                CW   = pack_cnt_width(PACK);
    localparam int                WW   = DATA_WIDTH * PACK;
    localparam logic [CW-1:0]     FULL = CW'(PACK);

    state_t                 state_q, state_d;
    logic [WW-1:0]          pack_q, pack_d, pack_land;
    logic [CW-1:0]          pack_cnt_q, pack_cnt_d, cnt_land;
    logic                   inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]   word_count_q, word_count_d;
    logic [CW:0]            occupancy;
    logic                   load, load_last, out_free;
    logic [PACK-1:0]        load_keep;

    // Counting the in-flight pop keeps the pack register from ever being overrun.
    assign occupancy  = {1'b0, pack_cnt_q} + {{CW{1'b0}}, inflight_q};
    assign fifo_rd_en = !rd_rst && !fifo_empty && (state_q == FILL)
                        && (occupancy < (CW+1)'(PACK));
    assign inflight_d = fifo_rd_en;

    always_comb begin
        pack_land = pack_q;
        cnt_land  = pack_cnt_q;
        if (inflight_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (pack_cnt_q == CW'(i)) begin
                    pack_land[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
                end
            end
            cnt_land = pack_cnt_q + 1'b1;
        end
        for (int i = 0; i < PACK; i++) begin
            load_keep[i] = (CW'(i) < cnt_land);
        end
    end

    always_comb begin
        state_d    = state_q;
        pack_d     = pack_land;
        pack_cnt_d = cnt_land;
        load       = 1'b0;
        load_last  = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            FILL: begin
                // Completing on the landing cycle gives one word per PACK+1 cycles.
                if (cnt_land == FULL && out_free) begin
                    load = 1'b1;
                end
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_q) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (cnt_land == '0) begin
                    flush_done = 1'b1;
                    state_d    = FILL;
                end else if (out_free) begin
                    load       = 1'b1;
                    load_last  = 1'b1;
                    flush_done = 1'b1;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        if (load) begin
            pack_d     = '0;
            pack_cnt_d = '0;
        end
    end

    assign word_count_d = word_count_q + {{(CNT_WIDTH-1){1'b0}}, (out_valid && out_ready)};

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q      <= FILL;
            pack_q       <= '0;
            pack_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pack_q       <= pack_d;
            pack_cnt_q   <= pack_cnt_d;
            inflight_q   <= inflight_d;
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;

    fifo_out_reg #(
        .DW (WW),
        .KW (PACK)
    ) u_out_reg (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .load      (load),
        .load_data (pack_land),
        .load_keep (load_keep),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_free  (out_free),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - scoreboard bench for fifo_rd_packer
module tb_fifo_rd_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_rd_en;
    logic        flush;
    logic        flush_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [15:0] word_count;

    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;
    int          fd_cnt = 0;
    logic [7:0]  fq[$];
    word_t       exp_q[$];
    logic        popped;
    logic        hold_q = 1'b0;
    word_t       held;

    fifo_rd_packer #(
        .DATA_WIDTH (8),
        .PACK       (4),
        .CNT_WIDTH  (16)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .flush_done   (flush_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_last     (out_last),
        .word_count   (word_count)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: data appears one cycle after an accepted pop.
    always @(posedge rd_clk) begin
        popped = fifo_rd_en && !fifo_empty;
        #1;
        if (rd_rst) begin
            fq.delete();
        end else if (popped && fq.size() > 0) begin
            fifo_rd_data = fq.pop_front();
            pop_cnt++;
        end
        fifo_empty = (fq.size() == 0);
    end

    // Monitor: scoreboard compare on handshake, stability while stalled.
    always @(negedge rd_clk) begin
        if (!rd_rst) begin
            if (flush_done) fd_cnt++;
            if (hold_q) begin
                check("hold_stable", {out_valid, out_data, out_keep, out_last}, {1'b1, held});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", {out_data, out_keep, out_last});
                end else begin
                    check("word", {out_data, out_keep, out_last}, exp_q.pop_front());
                end
            end
            hold_q = out_valid && !out_ready;
            held   = '{data: out_data, keep: out_keep, last: out_last};
        end else begin
            hold_q = 1'b0;
        end
    end

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back('{data: d, keep: k, last: l});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || out_valid) && n < 200) begin
            @(negedge rd_clk);
            n++;
        end
        check(name, 64'(n < 200), 64'd1);
        repeat (3) @(negedge rd_clk);
    endtask

    initial begin
        int base;
        rd_rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge rd_clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        rd_rst = 1'b0;
        @(negedge rd_clk);

        out_ready = 1'b1;
        expect_word(32'h44332211, 4'hF, 1'b0);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_idle("t1_idle");
        check("t1_count", 64'(word_count), 64'd1);

        out_ready = 1'b0;
        base = pop_cnt;
        expect_word(32'hA4A3A2A1, 4'hF, 1'b0);
        expect_word(32'hA8A7A6A5, 4'hF, 1'b0);
        expect_word(32'hACABAAA9, 4'hF, 1'b0);
        for (int i = 1; i <= 12; i++) push(8'hA0 + 8'(i));
        repeat (30) @(negedge rd_clk);
        check("t2_pops", 64'(pop_cnt - base), 64'd8);
        check("t2_rd_en", 64'(fifo_rd_en), 64'd0);
        check("t2_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_idle("t2_idle");
        check("t2_count", 64'(word_count), 64'd4);

        base = fd_cnt;
        expect_word(32'h0000BBAA, 4'h3, 1'b1);
        push(8'hAA); push(8'hBB);
        repeat (10) @(negedge rd_clk);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        wait_idle("t3_idle");
        check("t3_flush_done", 64'(fd_cnt - base), 64'd1);

        base = fd_cnt;
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        repeat (2) @(negedge rd_clk);
        check("t4_flush_done", 64'(fd_cnt - base), 64'd1);
        check("t4_no_valid", 64'(out_valid), 64'd0);
        repeat (3) @(negedge rd_clk);

        expect_word(32'h00CCBBAA, 4'h7, 1'b1);
        push(8'hAA); push(8'hBB);
        repeat (10) @(negedge rd_clk);
        push(8'hCC);
        @(negedge rd_clk);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        wait_idle("t5_idle");
        check("t5_count", 64'(word_count), 64'd6);

        push(8'h01); push(8'h02); push(8'h03);
        repeat (3) @(negedge rd_clk);
        rd_rst = 1'b1;
        #1;
        check("t6_rst_outs", {out_valid, out_data, out_keep, out_last, fifo_rd_en, flush_done},
              {1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0});
        check("t6_rst_count", 64'(word_count), 64'd0);
        repeat (2) @(negedge rd_clk);
        rd_rst = 1'b0;
        @(negedge rd_clk);
        expect_word(32'h08070605, 4'hF, 1'b0);
        push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        wait_idle("t6_idle");
        check("t6_count", 64'(word_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
